// File: rtl/gpio_in_filter.sv
// -----------------------------------------------------------------------------
// gpio_in_filter
//
// Input conditioning between the GPIO pads and the SoC gpio_in bus. Each pad
// bit is brought into the clk domain through a two-flop synchroniser and then
// debounced by a per-pin glitch counter with a live-programmable threshold.
// The committed (stable) vector drives gpio_o.
//
// Optional edge-capture unit, enabled by defining GPIO_IN_FILTER_EDGE_IRQ_EN:
// a registered one-cycle pulse per filtered transition (edge_o), sticky
// per-pin status bits (status_o) with level-sampled clear, and irq_o as the
// OR of all status bits. With the macro undefined those outputs are tied to
// 0, status_clr_i is ignored and no edge-capture flops exist.
//
// Parameters:
//   NB_PINS      number of filtered inputs
//   CNT_WIDTH    width of the per-pin glitch counter and of the threshold
//
// Ports:
//   clk           single clock
//   rst_n         asynchronous active-low reset
//   pad_in_i      raw pad inputs, asynchronous to clk
//   cfg_en_i      1 = debounce active, 0 = bypass after the synchroniser
//   cfg_thresh_i  stable-cycle threshold T (0 behaves as 1)
//   gpio_o        filtered stable vector
//   edge_o        one-cycle pulse per pin on each filtered transition
//   status_clr_i  per-pin clear of the sticky status, level-sampled
//   status_o      sticky edge status
//   irq_o         OR-reduction of status_o
// -----------------------------------------------------------------------------
module gpio_in_filter #(
    parameter int NB_PINS   = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NB_PINS-1:0]   pad_in_i,
    input  logic                 cfg_en_i,
    input  logic [CNT_WIDTH-1:0] cfg_thresh_i,
    output logic [NB_PINS-1:0]   gpio_o,
    output logic [NB_PINS-1:0]   edge_o,
    input  logic [NB_PINS-1:0]   status_clr_i,
    output logic [NB_PINS-1:0]   status_o,
    output logic                 irq_o
);

    // Threshold of zero would commit with no qualification at all; treat it
    // as one so the shortest filter still needs one confirming cycle.
    function automatic logic [CNT_WIDTH:0] eff_thresh(input logic [CNT_WIDTH-1:0] t);
        logic [CNT_WIDTH:0] r;
        if (t == '0) begin
            r = {{CNT_WIDTH{1'b0}}, 1'b1};
        end else begin
            r = {1'b0, t};
        end
        return r;
    endfunction

    localparam logic [CNT_WIDTH:0] CNT_ONE = {{CNT_WIDTH{1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // Two-flop synchroniser
    // -------------------------------------------------------------------------
    logic [NB_PINS-1:0] sync1_q, sync1_d;
    logic [NB_PINS-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = pad_in_i;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // -------------------------------------------------------------------------
    // Per-pin debounce counter and stable value
    // -------------------------------------------------------------------------
    logic [NB_PINS-1:0]                stable_q, stable_d;
    logic [NB_PINS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH:0]                thresh_eff;

    assign thresh_eff = eff_thresh(cfg_thresh_i);

    always_comb begin
        logic [CNT_WIDTH:0] cnt_inc;
        cnt_inc  = '0;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NB_PINS; i++) begin
            // One extra bit so cnt+1 is compared without wrapping; the commit
            // fires before the counter could ever reach 2^CNT_WIDTH.
            cnt_inc = {1'b0, cnt_q[i]} + CNT_ONE;
            if (!cfg_en_i) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else if (sync2_q[i] == stable_q[i]) begin
                // Input agrees with the committed value: any partial glitch
                // count is discarded.
                cnt_d[i] = '0;
            end else if (cnt_inc >= thresh_eff) begin
                // Threshold is sampled live, so lowering it mid-count can
                // commit on this very edge.
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_inc[CNT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gpio_o = stable_q;

`ifdef GPIO_IN_FILTER_EDGE_IRQ_EN
    // -------------------------------------------------------------------------
    // Edge capture: a delayed copy of stable lets edge_o rise on the cycle
    // after stable changes; status sets on the same edge so both are visible
    // together. Set takes priority over a coincident clear.
    // -------------------------------------------------------------------------
    logic [NB_PINS-1:0] stable_dly_q, stable_dly_d;
    logic [NB_PINS-1:0] edge_q, edge_d;
    logic [NB_PINS-1:0] status_q, status_d;

    always_comb begin
        stable_dly_d = stable_q;
        edge_d       = stable_q ^ stable_dly_q;
        status_d     = (status_q & ~status_clr_i) | edge_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_dly_q <= '0;
            edge_q       <= '0;
            status_q     <= '0;
        end else begin
            stable_dly_q <= stable_dly_d;
            edge_q       <= edge_d;
            status_q     <= status_d;
        end
    end

    assign edge_o   = edge_q;
    assign status_o = status_q;
    assign irq_o    = |status_q;
`else
    logic unused_status_clr;
    assign unused_status_clr = ^status_clr_i;

    assign edge_o   = '0;
    assign status_o = '0;
    assign irq_o    = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_filter.sv
// -----------------------------------------------------------------------------
// tb_gpio_in_filter
//
// Directed bench for gpio_in_filter (NB_PINS=32, CNT_WIDTH=8). Inputs are
// changed 1 ns after a rising edge and outputs sampled at the same point, so
// "edge i" below means the i-th rising edge after the pad change (edge 1 is
// the sync1 capture edge). Edge-capture expectations collapse to 0 when the
// design is built without GPIO_IN_FILTER_EDGE_IRQ_EN.
// -----------------------------------------------------------------------------
module tb_gpio_in_filter;

`ifdef GPIO_IN_FILTER_EDGE_IRQ_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] pad_in_i;
    logic        cfg_en_i;
    logic [7:0]  cfg_thresh_i;
    logic [31:0] gpio_o;
    logic [31:0] edge_o;
    logic [31:0] status_clr_i;
    logic [31:0] status_o;
    logic        irq_o;

    int errors;
    int checks;

    gpio_in_filter #(
        .NB_PINS   (32),
        .CNT_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pad_in_i     (pad_in_i),
        .cfg_en_i     (cfg_en_i),
        .cfg_thresh_i (cfg_thresh_i),
        .gpio_o       (gpio_o),
        .edge_o       (edge_o),
        .status_clr_i (status_clr_i),
        .status_o     (status_o),
        .irq_o        (irq_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] edge_exp(input bit cond, input logic [31:0] v);
        return (EDGE_EN && cond) ? v : 32'h0;
    endfunction

    task automatic clear_status();
        status_clr_i = '1;
        step(1);
        status_clr_i = '0;
    endtask

    logic [31:0] pv;

    initial begin
        errors       = 0;
        checks       = 0;
        rst_n        = 1'b0;
        cfg_en_i     = 1'b1;
        cfg_thresh_i = 8'd4;
        pad_in_i     = '0;
        status_clr_i = '0;

        // Reset state
        #3;
        check("rst_gpio",   gpio_o,        32'h0);
        check("rst_edge",   edge_o,        32'h0);
        check("rst_status", status_o,      32'h0);
        check("rst_irq",    {31'h0, irq_o}, 32'h0);
        step(2);
        rst_n = 1'b1;
        step(3);

        // T=4 step on pin 0: commit at edge 6, edge pulse at edge 7
        pad_in_i = 32'h1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            check("t1_gpio",   gpio_o,   (i >= 6) ? 32'h1 : 32'h0);
            check("t1_edge",   edge_o,   edge_exp(i == 7, 32'h1));
            check("t1_status", status_o, edge_exp(i >= 7, 32'h1));
        end
        check("t1_irq", {31'h0, irq_o}, {31'h0, EDGE_EN});
        clear_status();
        check("t1_clr_status", status_o, 32'h0);
        check("t1_clr_irq", {31'h0, irq_o}, 32'h0);

        // 3-cycle glitch on pin 5 is rejected
        pad_in_i = 32'h21;
        step(3);
        pad_in_i = 32'h1;
        for (int i = 4; i <= 13; i++) begin
            step(1);
            check("t2_glitch_gpio", gpio_o, 32'h1);
            check("t2_glitch_edge", edge_o, 32'h0);
        end

        // 4-cycle pulse on pin 5 commits (edge 6), then falls back (edge 10)
        pad_in_i = 32'h21;
        for (int i = 1; i <= 11; i++) begin
            step(1);
            if (i == 4) pad_in_i = 32'h1;
            check("t2_pulse_gpio", gpio_o, (i >= 6 && i <= 9) ? 32'h21 : 32'h1);
            check("t2_pulse_edge", edge_o, edge_exp(i == 7 || i == 11, 32'h20));
        end
        check("t2_status", status_o, edge_exp(1'b1, 32'h20));
        clear_status();

        // T=0 and T=1 both commit at edge 3
        cfg_thresh_i = 8'd0;
        pad_in_i     = 32'h3;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            check("t3_t0_gpio", gpio_o, (i >= 3) ? 32'h3 : 32'h1);
        end
        cfg_thresh_i = 8'd1;
        pad_in_i     = 32'h1;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            check("t3_t1_gpio", gpio_o, (i >= 3) ? 32'h1 : 32'h3);
        end

        // T=255: commit at edge 257, counter must not wrap
        cfg_thresh_i = 8'd255;
        pad_in_i     = 32'h5;
        for (int i = 1; i <= 258; i++) begin
            step(1);
            if (i == 256) check("t3_t255_pre",  gpio_o, 32'h1);
            if (i == 257) check("t3_t255_post", gpio_o, 32'h5);
            if (i == 258) check("t3_t255_edge", edge_o, edge_exp(1'b1, 32'h4));
        end
        cfg_thresh_i = 8'd1;
        pad_in_i     = 32'h1;
        step(4);
        check("t3_restore", gpio_o, 32'h1);
        clear_status();

        // T=10, all pins toggle; T lowered to 2 after 5 counted cycles
        cfg_thresh_i = 8'd10;
        pad_in_i     = 32'hFFFF_FFFE;
        for (int i = 1; i <= 9; i++) begin
            step(1);
            check("t4_gpio", gpio_o, (i >= 8) ? 32'hFFFF_FFFE : 32'h1);
            check("t4_edge", edge_o, edge_exp(i == 9, 32'hFFFF_FFFF));
            if (i == 7) cfg_thresh_i = 8'd2;
        end
        check("t4_status", status_o, edge_exp(1'b1, 32'hFFFF_FFFF));

        // Status set/clear priority on pin 3
        clear_status();
        check("t5_cleared", status_o, 32'h0);
        cfg_thresh_i = 8'd1;
        pv           = 32'hFFFF_FFF6;
        pad_in_i     = pv;
        step(4);
        check("t5_first_edge",   edge_o,   edge_exp(1'b1, 32'h8));
        check("t5_first_status", status_o, edge_exp(1'b1, 32'h8));
        step(1);
        pv       = pv ^ 32'h8;
        pad_in_i = pv;
        step(3);
        status_clr_i = 32'h8;
        step(1);
        check("t5_setwins_edge",   edge_o,   edge_exp(1'b1, 32'h8));
        check("t5_setwins_status", status_o, edge_exp(1'b1, 32'h8));
        step(1);
        status_clr_i = '0;
        check("t5_lone_clr_status", status_o, 32'h0);
        check("t5_lone_clr_irq", {31'h0, irq_o}, 32'h0);
        check("t5_gpio", gpio_o, pv);

        // Bypass mode, async reset mid-cycle, then bypass latency of 3 edges
        cfg_en_i     = 1'b0;
        cfg_thresh_i = 8'd10;
        pv           = pv ^ 32'h80;
        pad_in_i     = pv;
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_gpio",   gpio_o,   32'h0);
        check("t6_rst_edge",   edge_o,   32'h0);
        check("t6_rst_status", status_o, 32'h0);
        check("t6_rst_irq", {31'h0, irq_o}, 32'h0);
        step(1);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            check("t6_byp_gpio", gpio_o, (i >= 3) ? pv : 32'h0);
            check("t6_byp_edge", edge_o, edge_exp(i == 4, pv));
        end
        check("t6_irq", {31'h0, irq_o}, {31'h0, EDGE_EN});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
